// File: rtl/zelda_map_pkg.sv
// Shared types and constants for the overworld map renderer.
package zelda_map_pkg;

  typedef logic [1:0] room_t;

  localparam room_t ROOM_LEFT   = 2'd0;
  localparam room_t ROOM_CENTER = 2'd1;
  localparam room_t ROOM_RIGHT  = 2'd2;

  localparam int H_RES = 640;
  localparam int V_RES = 480;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCROLL_R = 2'd1,
    SCROLL_L = 2'd2
  } scroll_state_e;

endpackage

// File: rtl/scroll_pixel_mapper.sv
// Maps the screen pixel to a room image and an x inside it, then registers
// the result so it lines up one vga_clk after DrawX/DrawY/blank.
module scroll_pixel_mapper
  import zelda_map_pkg::*;
#(
  parameter int RESET_ROOM = 1
) (
  input  logic          vga_clk,
  input  logic          reset_n,
  input  scroll_state_e state,
  input  room_t         cur_room,
  input  logic [9:0]    scroll_x,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic          blank,
  output room_t         pix_room,
  output logic [9:0]    pix_x,
  output logic [9:0]    pix_y,
  output logic          blank_d
);

  localparam logic [10:0] H_RES_11 = 11'(H_RES);
  localparam logic [9:0]  H_RES_10 = 10'(H_RES);

  logic [10:0] sx;
  logic [9:0]  sx_wrap;
  room_t       map_room;
  logic [9:0]  map_x;

  // Place DrawX in a two-room strip; anything past 640 belongs to the right-hand room.
  always_comb begin
    sx = {1'b0, DrawX};
    if (state == SCROLL_R) begin
      sx = {1'b0, DrawX} + {1'b0, scroll_x};
    end else if (state == SCROLL_L) begin
      sx = {1'b0, DrawX} + H_RES_11 - {1'b0, scroll_x};
    end
    sx_wrap  = sx[9:0] - H_RES_10;
    map_room = cur_room;
    map_x    = sx[9:0];
    if (sx >= H_RES_11) begin
      map_x = sx_wrap;
      if (state == SCROLL_R) begin
        map_room = cur_room + 2'd1;
      end
    end else if (state == SCROLL_L) begin
      map_room = cur_room - 2'd1;
    end
  end

  // One pipeline stage so room, x, y and blank all arrive together downstream.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_room <= room_t'(RESET_ROOM);
      pix_x    <= '0;
      pix_y    <= '0;
      blank_d  <= 1'b0;
    end else begin
      pix_room <= map_room;
      pix_x    <= map_x;
      pix_y    <= DrawY;
      blank_d  <= blank;
    end
  end

endmodule

// File: rtl/room_scroll_ctrl.sv
// Room transition sequencer: accepts edge requests, advances the scroll offset
// once per frame and commits the neighbouring room when the scroll completes.
module room_scroll_ctrl
  import zelda_map_pkg::*;
#(
  parameter int NUM_ROOMS   = 3,
  parameter int RESET_ROOM  = 1,
  parameter int SCROLL_STEP = 4
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       req_left,
  input  logic       req_right,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  output logic [1:0] cur_room,
  output logic       busy,
  output logic       done,
  output logic [9:0] scroll_x,
  output logic [1:0] pix_room,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       blank_d
);

  localparam room_t       LAST_ROOM = room_t'(NUM_ROOMS - 1);
  localparam logic [10:0] STEP_11   = 11'(SCROLL_STEP);
  localparam logic [10:0] H_RES_11  = 11'(H_RES);

  scroll_state_e state;
  logic [10:0]   next_x;
  logic          can_advance;

  assign next_x      = {1'b0, scroll_x} + STEP_11;
  assign can_advance = (next_x < H_RES_11);
  assign busy        = (state != IDLE);

  // Scroll FSM: requests are only honoured in IDLE, and the offset only moves on frame_start.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cur_room <= room_t'(RESET_ROOM);
      scroll_x <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_right && !req_left && (cur_room < LAST_ROOM)) begin
            state    <= SCROLL_R;
            scroll_x <= '0;
          end else if (req_left && !req_right && (cur_room != '0)) begin
            state    <= SCROLL_L;
            scroll_x <= '0;
          end
        end
        SCROLL_R, SCROLL_L: begin
          if (frame_start) begin
            if (can_advance) begin
              scroll_x <= next_x[9:0];
            end else begin
              scroll_x <= '0;
              cur_room <= (state == SCROLL_R) ? cur_room + 2'd1 : cur_room - 2'd1;
              done     <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  scroll_pixel_mapper #(
    .RESET_ROOM(RESET_ROOM)
  ) u_mapper (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .state   (state),
    .cur_room(cur_room),
    .scroll_x(scroll_x),
    .DrawX   (DrawX),
    .DrawY   (DrawY),
    .blank   (blank),
    .pix_room(pix_room),
    .pix_x   (pix_x),
    .pix_y   (pix_y),
    .blank_d (blank_d)
  );

endmodule
